// File: rtl/seg_disp_pkg.sv
// rtl/seg_disp_pkg.sv - shared constants and hex glyph table for the 7-segment scan driver
package seg_disp_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low {g,f,e,d,c,b,a}; element n is the glyph for hex digit n.
  localparam logic [15:0][6:0] HEX_GLYPH = {
    7'h0E,  // F
    7'h06,  // E
    7'h21,  // d
    7'h46,  // C
    7'h03,  // b
    7'h08,  // A
    7'h10,  // 9
    7'h00,  // 8
    7'h78,  // 7
    7'h02,  // 6
    7'h12,  // 5
    7'h19,  // 4
    7'h30,  // 3
    7'h24,  // 2
    7'h79,  // 1
    7'h40   // 0
  };

endpackage

// File: rtl/seg7_hex_decoder.sv
// rtl/seg7_hex_decoder.sv - combinational nibble to active-low 7-segment glyph
module seg7_hex_decoder
  import seg_disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  assign seg_n = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - time-multiplexed hex display driver with frame-latched data
module seg_scan_display
  import seg_disp_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   data,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  blank_lz,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int PW = (PRESCALE > 1)     ? $clog2(PRESCALE)     : 1;
  localparam int IW = (DIGITS > 1)       ? $clog2(DIGITS)       : 1;
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] I_LAST = IW'(DIGITS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_FRAMES - 1);

  logic [PW-1:0]         pcnt;
  logic [IW-1:0]         idx;
  logic [BW-1:0]         bcnt;
  logic                  blink_ph;
  logic                  tick;
  logic                  wrap;

  logic [4*DIGITS-1:0]   snap_data;
  logic [DIGITS-1:0]     snap_dp;
  logic [DIGITS-1:0]     snap_blink;
  logic                  snap_lz;

  logic [DIGITS-1:0]     lz_blank;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_blank;
  logic [6:0]            glyph;

  assign tick = (pcnt == P_LAST);
  assign wrap = tick && (idx == I_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt     <= '0;
      idx      <= '0;
      bcnt     <= '0;
      blink_ph <= 1'b0;
    end else begin
      pcnt <= tick ? '0 : pcnt + 1'b1;
      if (tick) begin
        idx <= (idx == I_LAST) ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        if (bcnt == B_LAST) begin
          bcnt     <= '0;
          blink_ph <= ~blink_ph;
        end else begin
          bcnt <= bcnt + 1'b1;
        end
      end
    end
  end

  // Inputs are only observed at reset and frame wrap so a frame never mixes two values.
  always_ff @(posedge clk) begin
    if (!rst_n || wrap) begin
      snap_data  <= data;
      snap_dp    <= dp_mask;
      snap_blink <= blink_mask;
      snap_lz    <= blank_lz;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
    end
  end

  // Walk from the most significant digit down; a lit dp ends the run of blankable zeros.
  always_comb begin
    logic run;
    run      = 1'b1;
    lz_blank = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      run = run && (snap_data[4*i +: 4] == 4'h0) && !snap_dp[i];
      if (i != 0) begin
        lz_blank[i] = snap_lz && run;
      end
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib   = snap_data[4*i +: 4];
        cur_dp    = snap_dp[i];
        cur_blank = lz_blank[i] || (snap_blink[i] && blink_ph);
      end
    end
  end

  seg7_hex_decoder u_dec (
    .nibble (cur_nib),
    .seg_n  (glyph)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || cur_blank) begin
      an  <= '1;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(DIGITS'(1) << idx);
      seg <= {~cur_dp, glyph};
    end
  end

endmodule
